mips_ctrl_alu: RTL and testbench

- Single-cycle MIPS execute-stage slice: main control decoder, ALU-control decoder and 32-bit ALU in one block, with a registered output stage.
- Sits between instruction memory (opcode/funct) and the register file / data memory / PC-update logic.
- Operand selection (register vs sign-extended immediate) stays outside; the block receives the final two ALU operands.

---
 rtl/mips_ctrl_alu.sv | 162 ++++++++++++++++
 tb/tb_mips_ctrl_alu.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mips_ctrl_alu.sv
// MIPS execute-stage slice: main decoder, ALU-control decoder and ALU,
// with every output captured in one register stage.
module mips_ctrl_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic [5:0]       op_code,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             reg_dst,
    output logic             jump,
    output logic             branch,
    output logic             mem_read,
    output logic             mem_to_reg,
    output logic             mem_write,
    output logic             alu_src,
    output logic             reg_write,
    output logic [1:0]       alu_op,
    output logic [3:0]       alu_ctr,
    output logic [WIDTH-1:0] alu_res,
    output logic             zero
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_BAD = 4'b1111;

    logic             reg_dst_next, jump_next, branch_next, mem_read_next;
    logic             mem_to_reg_next, mem_write_next, alu_src_next, reg_write_next;
    logic [1:0]       alu_op_next;
    logic [3:0]       alu_ctr_next;
    logic [WIDTH-1:0] alu_res_next;
    logic             zero_next;
    logic [WIDTH-1:0] and_bits, or_bits, nor_bits;

    // Main decoder: unknown opcodes fall through with every strobe low.
    always_comb begin
        reg_dst_next    = 1'b0;
        alu_src_next    = 1'b0;
        mem_to_reg_next = 1'b0;
        reg_write_next  = 1'b0;
        mem_read_next   = 1'b0;
        mem_write_next  = 1'b0;
        branch_next     = 1'b0;
        jump_next       = 1'b0;
        alu_op_next     = 2'b00;
        case (op_code)
            OP_RTYPE: begin
                reg_dst_next   = 1'b1;
                reg_write_next = 1'b1;
                alu_op_next    = 2'b10;
            end
            OP_LW: begin
                alu_src_next    = 1'b1;
                mem_to_reg_next = 1'b1;
                reg_write_next  = 1'b1;
                mem_read_next   = 1'b1;
            end
            OP_SW: begin
                alu_src_next   = 1'b1;
                mem_write_next = 1'b1;
            end
            OP_BEQ: begin
                branch_next = 1'b1;
                alu_op_next = 2'b01;
            end
            OP_J:    jump_next = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        alu_ctr_next = ALU_BAD;
        case (alu_op_next)
            2'b00: alu_ctr_next = ALU_ADD;
            2'b01: alu_ctr_next = ALU_SUB;
            2'b10: begin
                case (funct)
                    FN_ADD:  alu_ctr_next = ALU_ADD;
                    FN_SUB:  alu_ctr_next = ALU_SUB;
                    FN_AND:  alu_ctr_next = ALU_AND;
                    FN_OR:   alu_ctr_next = ALU_OR;
                    FN_SLT:  alu_ctr_next = ALU_SLT;
                    FN_NOR:  alu_ctr_next = ALU_NOR;
                    default: alu_ctr_next = ALU_BAD;
                endcase
            end
            default: alu_ctr_next = ALU_BAD;
        endcase
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_logic
        assign and_bits[gi] = input1[gi] & input2[gi];
        assign or_bits[gi]  = input1[gi] | input2[gi];
        assign nor_bits[gi] = ~(input1[gi] | input2[gi]);
    end

    // The ALU runs on the same-cycle control code, not the registered one.
    always_comb begin
        alu_res_next = '0;
        case (alu_ctr_next)
            ALU_AND: alu_res_next = and_bits;
            ALU_OR:  alu_res_next = or_bits;
            ALU_ADD: alu_res_next = input1 + input2;
            ALU_SUB: alu_res_next = input1 - input2;
            ALU_SLT: alu_res_next = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
            ALU_NOR: alu_res_next = nor_bits;
            default: alu_res_next = '0;
        endcase
        zero_next = (alu_res_next == '0);
    end

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            reg_dst    <= 1'b0;
            jump       <= 1'b0;
            branch     <= 1'b0;
            mem_read   <= 1'b0;
            mem_to_reg <= 1'b0;
            mem_write  <= 1'b0;
            alu_src    <= 1'b0;
            reg_write  <= 1'b0;
            alu_op     <= 2'b00;
            alu_ctr    <= 4'b0000;
            alu_res    <= '0;
            zero       <= 1'b0;
        end else begin
            reg_dst    <= reg_dst_next;
            jump       <= jump_next;
            branch     <= branch_next;
            mem_read   <= mem_read_next;
            mem_to_reg <= mem_to_reg_next;
            mem_write  <= mem_write_next;
            alu_src    <= alu_src_next;
            reg_write  <= reg_write_next;
            alu_op     <= alu_op_next;
            alu_ctr    <= alu_ctr_next;
            alu_res    <= alu_res_next;
            zero       <= zero_next;
        end
    end

endmodule

// File: tb/tb_mips_ctrl_alu.sv
// Directed bench for mips_ctrl_alu; expected results queue up as each
// instruction is driven and are checked one cycle later.
module tb_mips_ctrl_alu;

    logic        clock_in = 1'b0;
    logic        reset;
    logic [5:0]  op_code, funct;
    logic [31:0] input1, input2;
    logic        reg_dst, jump, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
    logic [1:0]  alu_op;
    logic [3:0]  alu_ctr;
    logic [31:0] alu_res;
    logic        zero;

    int n_assert = 0;
    int n_fail   = 0;

    // ctrl packs {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump, alu_op}
    typedef struct packed {
        logic [9:0]  ctrl;
        logic [3:0]  ctr;
        logic [31:0] res;
        logic        z;
    } exp_t;

    exp_t sb[$];

    mips_ctrl_alu #(.WIDTH(32)) dut (
        .clock_in  (clock_in),
        .reset     (reset),
        .op_code   (op_code),
        .funct     (funct),
        .input1    (input1),
        .input2    (input2),
        .reg_dst   (reg_dst),
        .jump      (jump),
        .branch    (branch),
        .mem_read  (mem_read),
        .mem_to_reg(mem_to_reg),
        .mem_write (mem_write),
        .alu_src   (alu_src),
        .reg_write (reg_write),
        .alu_op    (alu_op),
        .alu_ctr   (alu_ctr),
        .alu_res   (alu_res),
        .zero      (zero)
    );

    always #5 clock_in = ~clock_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] ctrl_obs();
        return {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump, alu_op};
    endfunction

    task automatic check_cleared(input string tag);
        chk({tag, "_ctrl"}, {22'd0, ctrl_obs()}, 32'd0);
        chk({tag, "_ctr"},  {28'd0, alu_ctr},    32'd0);
        chk({tag, "_res"},  alu_res,             32'd0);
        chk({tag, "_zero"}, {31'd0, zero},       32'd0);
    endtask

    task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [9:0] c, input logic [3:0] ctr,
                        input logic [31:0] res, input logic z);
        exp_t e;
        op_code = op;
        funct   = fn;
        input1  = a;
        input2  = b;
        sb.push_back('{ctrl: c, ctr: ctr, res: res, z: z});
        @(posedge clock_in);
        #1;
        n_assert++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL %s_queue: observed empty expected entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_ctrl"}, {22'd0, ctrl_obs()}, {22'd0, e.ctrl});
            chk({tag, "_ctr"},  {28'd0, alu_ctr},    {28'd0, e.ctr});
            chk({tag, "_res"},  alu_res,             e.res);
            chk({tag, "_zero"}, {31'd0, zero},       {31'd0, e.z});
        end
        $display("step %-10s op=%b fn=%b a=0x%08h b=0x%08h -> res=0x%08h ctr=%b zero=%b",
                 tag, op, fn, a, b, alu_res, alu_ctr, zero);
    endtask

    localparam logic [9:0] C_R   = 10'b1001000010;
    localparam logic [9:0] C_LW  = 10'b0111100000;
    localparam logic [9:0] C_SW  = 10'b0100010000;
    localparam logic [9:0] C_BEQ = 10'b0000001001;
    localparam logic [9:0] C_J   = 10'b0000000100;
    localparam logic [9:0] C_NONE = 10'b0000000000;

    initial begin
        reset   = 1'b0;
        op_code = 6'b000000;
        funct   = 6'b100000;
        input1  = 32'd5;
        input2  = 32'd7;
        repeat (2) @(posedge clock_in);
        #1;
        check_cleared("reset_hold");
        $display("step reset_hold outputs res=0x%08h zero=%b", alu_res, zero);

        reset = 1'b1;
        step("rst_rel",  6'b000000, 6'b100000, 32'd5, 32'd7, C_R, 4'b0010, 32'd12, 1'b0);
        step("lw",       6'b100011, 6'b000000, 32'h100, 32'h4, C_LW, 4'b0010, 32'h104, 1'b0);
        step("sw",       6'b101011, 6'b000000, 32'h100, 32'h4, C_SW, 4'b0010, 32'h104, 1'b0);
        step("beq_eq",   6'b000100, 6'b000000, 32'hDEADBEEF, 32'hDEADBEEF, C_BEQ, 4'b0110, 32'd0, 1'b1);
        step("beq_ne",   6'b000100, 6'b000000, 32'hDEADBEEF, 32'hDEADBEEE, C_BEQ, 4'b0110, 32'd1, 1'b0);
        step("r_and",    6'b000000, 6'b100100, 32'hF0F0F0F0, 32'h0FF00FF0, C_R, 4'b0000, 32'h00F000F0, 1'b0);
        step("r_or",     6'b000000, 6'b100101, 32'hF0F0F0F0, 32'h0FF00FF0, C_R, 4'b0001, 32'hFFF0FFF0, 1'b0);
        step("r_nor",    6'b000000, 6'b100111, 32'hF0F0F0F0, 32'h0FF00FF0, C_R, 4'b1100, 32'h000F000F, 1'b0);
        step("r_sub",    6'b000000, 6'b100010, 32'hF0F0F0F0, 32'h0FF00FF0, C_R, 4'b0110, 32'hE100E100, 1'b0);
        step("slt_neg",  6'b000000, 6'b101010, 32'hFFFFFFFF, 32'd1, C_R, 4'b0111, 32'd1, 1'b0);
        step("slt_swap", 6'b000000, 6'b101010, 32'd1, 32'hFFFFFFFF, C_R, 4'b0111, 32'd0, 1'b1);
        step("slt_min",  6'b000000, 6'b101010, 32'h80000000, 32'h7FFFFFFF, C_R, 4'b0111, 32'd1, 1'b0);
        step("add_wrap", 6'b000000, 6'b100000, 32'hFFFFFFFF, 32'd1, C_R, 4'b0010, 32'd0, 1'b1);
        step("jump",     6'b000010, 6'b000000, 32'd3, 32'd4, C_J, 4'b0010, 32'd7, 1'b0);
        step("bad_op",   6'b111111, 6'b000000, 32'd3, 32'd4, C_NONE, 4'b0010, 32'd7, 1'b0);
        step("bad_fn",   6'b000000, 6'b111111, 32'd3, 32'd4, C_R, 4'b1111, 32'd0, 1'b1);
        step("lw_again", 6'b100011, 6'b000000, 32'h100, 32'h4, C_LW, 4'b0010, 32'h104, 1'b0);

        // Pull reset between edges: outputs must clear without a clock edge.
        #2;
        reset = 1'b0;
        #1;
        check_cleared("async_clr");
        $display("step async_clr outputs res=0x%08h zero=%b", alu_res, zero);
        @(posedge clock_in);
        #1;
        check_cleared("rst_held");
        $display("step rst_held outputs res=0x%08h zero=%b", alu_res, zero);

        reset = 1'b1;
        step("post_rst", 6'b000000, 6'b100010, 32'd10, 32'd3, C_R, 4'b0110, 32'd7, 1'b0);

        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain: observed %0d entries expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
